flap_command_scheduler: RTL

- Queues flap-indicator commands from a single requester and replays them to N_IND flap indicators as one-cycle change_mode / change_position pulses.
- Enforces a per-indicator mechanical holdoff between pulses to the same indicator.
- Sits between the debounced front-panel / host command source and the flap indicator array. It replaces the direct selector gating with a queued, paced scheduler.

---
 rtl/flap_pkg.sv | 18 +
 rtl/flap_command_scheduler_if.sv | 25 ++
 rtl/flap_cmd_fifo.sv | 63 ++++++
 rtl/flap_command_scheduler.sv | 112 +++++++++++
 4 files changed

// File: rtl/flap_pkg.sv
// Shared definitions for the flap command scheduler: default sizing,
// command op encoding and the queued command record.
package flap_pkg;

  localparam int DEFAULT_N_IND = 4;
  localparam int DEFAULT_IDX_W = 2;

  typedef enum logic {
    OP_POSITION = 1'b0,
    OP_MODE     = 1'b1
  } flap_op_e;

  typedef struct packed {
    logic [DEFAULT_IDX_W-1:0] index;
    flap_op_e                 op;
  } flap_cmd_t;

endpackage

// File: rtl/flap_command_scheduler_if.sv
// Command handshake between the requester (master) and the scheduler (slave).
interface flap_command_scheduler_if #(
  parameter int IDX_W = 2
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_index;
  logic             cmd_op;

  modport master (
    output cmd_valid,
    output cmd_index,
    output cmd_op,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_index,
    input  cmd_op,
    output cmd_ready
  );

endinterface

// File: rtl/flap_cmd_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
// Full/empty come from the count so the pointers may wrap freely.
module flap_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             sync_nreset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = push & ~w_full & ~flush;
  assign w_do_pop  = pop & ~w_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/flap_command_scheduler.sv
// Queues flap commands and replays them in order as one-cycle mode/position
// pulses, pacing pulses to the same indicator with a per-indicator holdoff.
module flap_command_scheduler
  import flap_pkg::*;
#(
  parameter int N_IND      = DEFAULT_N_IND,
  parameter int IDX_W      = DEFAULT_IDX_W,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 8,
  parameter int CNT_W      = 3
) (
  input  logic                     clk,
  input  logic                     sync_nreset,
  flap_command_scheduler_if.slave  cmd_if,
  input  logic                     flush,
  output logic [N_IND-1:0]         mode_pulse,
  output logic [N_IND-1:0]         position_pulse,
  output logic [N_IND-1:0]         active,
  output logic [CNT_W-1:0]         pending,
  output logic                     busy
);

  localparam int              HOLD_W    = 8;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

  logic [N_IND-1:0]  r_mode_pulse;
  logic [N_IND-1:0]  r_position_pulse;
  logic [N_IND-1:0]  r_active;
  logic [HOLD_W-1:0] r_hold [N_IND];

  logic [IDX_W:0]    w_head;
  logic [IDX_W-1:0]  w_head_idx;
  flap_op_e          w_head_op;
  logic [N_IND-1:0]  w_head_onehot;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_issue;
  logic              w_hold_any;

  assign cmd_if.cmd_ready = ~w_full & ~flush;
  assign w_push           = cmd_if.cmd_valid & cmd_if.cmd_ready;

  flap_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W + 1),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .sync_nreset (sync_nreset),
    .flush       (flush),
    .push        (w_push),
    .pop         (w_issue),
    .wdata       ({cmd_if.cmd_index, cmd_if.cmd_op}),
    .rdata       (w_head),
    .count       (w_count),
    .full        (w_full),
    .empty       (w_empty)
  );

  assign w_head_idx    = w_head[IDX_W:1];
  assign w_head_op     = flap_op_e'(w_head[0]);
  assign w_head_onehot = N_IND'(1) << w_head_idx;

  // Only the head is eligible; a held-off head blocks everything behind it.
  assign w_issue = ~w_empty & (r_hold[w_head_idx] == '0) & ~flush;

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      r_mode_pulse     <= '0;
      r_position_pulse <= '0;
      r_active         <= N_IND'(1);
      for (int unsigned i = 0; i < N_IND; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_mode_pulse     <= '0;
      r_position_pulse <= '0;
      if (w_issue) begin
        if (w_head_op == OP_MODE) begin
          r_mode_pulse <= w_head_onehot;
        end else begin
          r_position_pulse <= w_head_onehot;
        end
        r_active <= w_head_onehot;
      end
      // A load on the issue edge takes priority over the running decrement.
      for (int unsigned i = 0; i < N_IND; i++) begin
        if (w_issue && (w_head_idx == IDX_W'(i))) begin
          r_hold[i] <= HOLD_LOAD;
        end else if (r_hold[i] != '0) begin
          r_hold[i] <= r_hold[i] - HOLD_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_hold_any = 1'b0;
    for (int unsigned i = 0; i < N_IND; i++) begin
      w_hold_any = w_hold_any | (r_hold[i] != '0);
    end
  end

  assign mode_pulse     = r_mode_pulse;
  assign position_pulse = r_position_pulse;
  assign active         = r_active;
  assign pending        = w_count;
  assign busy           = ~w_empty | w_hold_any;

endmodule
